// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI4 slave endpoint for one single-port SRAM macro. It serves one
//   transaction at a time and splits each burst into per-word SRAM accesses.
// Ports
//   ACLK, ARESET                      : clock (rising edge), async active-high reset
//   AW* / W* / B*                     : AXI write address, data and response channels
//   AR* / R*                          : AXI read address and data channels
//   mem_cs, mem_we, mem_addr,
//   mem_wdata, mem_rdata              : SRAM macro interface (word addressed,
//                                       per-byte write enables, read data one
//                                       cycle after the access)
module axi_sram_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic                mem_cs,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0]        BURST_FIXED = 2'b00;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [LEN_W-1:0]  CNT_ONE     = LEN_W'(1);
    localparam logic [MEM_AW-1:0] ADDR_ONE    = MEM_AW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ID_W-1:0]     id_r;
    logic [MEM_AW-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [1:0]          burst_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [1:0]          bresp_r;
    logic [MEM_AW-1:0]   addr_next_s;
    logic                cnt_last_s;
    logic                aw_hs_s;
    logic                ar_hs_s;
    logic                w_hs_s;
    logic                w_last_s;
    logic                r_hs_s;
    logic                unused_s;

    // Size and the byte-offset / upper address bits carry no information for
    // a full-word, word-addressed SRAM.
    assign unused_s = ^{AWSIZE, ARSIZE, AWADDR, ARADDR};

    // FIXED bursts hold the address; INCR and WRAP step one word and wrap at
    // the top of the SRAM through natural MEM_AW-bit overflow.
    assign addr_next_s = (burst_r == BURST_FIXED) ? addr_r : addr_r + ADDR_ONE;
    assign cnt_last_s  = (cnt_r == len_r);
    assign w_last_s    = WLAST || cnt_last_s;

    assign aw_hs_s = (state_r == IDLE) && AWVALID;
    assign ar_hs_s = (state_r == IDLE) && !AWVALID && ARVALID;
    assign w_hs_s  = (state_r == WR_DATA) && WVALID;
    assign r_hs_s  = (state_r == RD_DATA) && RREADY;

    assign mem_addr = addr_r;
    assign BID      = id_r;
    assign RID      = id_r;
    assign BRESP    = bresp_r;
    assign RRESP    = RESP_OKAY;

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction context: captured on address handshakes, stepped per beat.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            id_r    <= {ID_W{1'b0}};
            addr_r  <= {MEM_AW{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            burst_r <= 2'b00;
            cnt_r   <= {LEN_W{1'b0}};
            bresp_r <= RESP_OKAY;
        end else if (aw_hs_s) begin
            id_r    <= AWID;
            addr_r  <= AWADDR[MEM_AW+1:2];
            len_r   <= AWLEN;
            burst_r <= AWBURST;
            cnt_r   <= {LEN_W{1'b0}};
        end else if (ar_hs_s) begin
            id_r    <= ARID;
            addr_r  <= ARADDR[MEM_AW+1:2];
            len_r   <= ARLEN;
            burst_r <= ARBURST;
            cnt_r   <= {LEN_W{1'b0}};
        end else if (w_hs_s) begin
            addr_r <= addr_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
            if (w_last_s) begin
                // Only a WLAST landing exactly on the announced length is clean.
                bresp_r <= (WLAST && cnt_last_s) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                bresp_r <= bresp_r;
            end
        end else if (r_hs_s && !cnt_last_s) begin
            addr_r <= addr_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Next state plus channel handshakes and SRAM strobes.
    always_comb begin
        state_s   = state_r;
        AWREADY   = 1'b0;
        ARREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RDATA     = {DATA_W{1'b0}};
        mem_cs    = 1'b0;
        mem_we    = {STRB_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        // Outputs are forced quiet while reset is held, not just after the edge.
        if (ARESET) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    AWREADY = 1'b1;
                    ARREADY = !AWVALID;
                    if (AWVALID) begin
                        state_s = WR_DATA;
                    end else if (ARVALID) begin
                        state_s = RD_REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WR_DATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        mem_cs    = 1'b1;
                        mem_we    = WSTRB;
                        mem_wdata = WDATA;
                        state_s   = w_last_s ? WR_RESP : WR_DATA;
                    end else begin
                        state_s = WR_DATA;
                    end
                end
                WR_RESP: begin
                    BVALID  = 1'b1;
                    state_s = BREADY ? IDLE : WR_RESP;
                end
                RD_REQ: begin
                    mem_cs  = 1'b1;
                    state_s = RD_DATA;
                end
                RD_DATA: begin
                    // SRAM holds its read data until the next chip select, so a
                    // stall keeps RDATA stable without a local copy.
                    RVALID = 1'b1;
                    RDATA  = mem_rdata;
                    RLAST  = cnt_last_s;
                    if (RREADY) begin
                        state_s = cnt_last_s ? IDLE : RD_REQ;
                    end else begin
                        state_s = RD_DATA;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

endmodule
